rx_ds_token: RTL and testbench

//  Consumes decoded N-chars/L-chars from rx_DS_char and turns them into link tokens.

---
 rtl/rx_ds_token.sv | 173 +++++++++++++++++
 tb/tb_rx_ds_token.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_ds_token.sv
// rx_ds_token: turns decoded N-chars/L-chars into link tokens
// (NULL, FCT, time codes, EOP/EEP) and queues data for the host side.
//
// Ports:
//   rxClk, rxReset      clock; asynchronous active-high reset
//   q, nchar, lchar     char from rx_DS_char (L-char code in q[1:0])
//   parityError         parity failure level from rx_DS_char
//   rdData, rdValid     FIFO head {marker, byte}; valid when non-empty
//   rdReady             pops the head when rdValid is high
//   fifoCount           entries currently held
//   gotNull/gotFct/tick one-cycle token pulses
//   timeCode            last time code received
//   nullSeen, escError, parError, overflow   sticky status flags
module rx_ds_token #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  rxClk,
    input  logic                  rxReset,
    input  logic [7:0]            q,
    input  logic                  nchar,
    input  logic                  lchar,
    input  logic                  parityError,
    output logic [8:0]            rdData,
    output logic                  rdValid,
    input  logic                  rdReady,
    output logic [DEPTH_LOG2:0]   fifoCount,
    output logic                  gotNull,
    output logic                  gotFct,
    output logic                  tick,
    output logic [7:0]            timeCode,
    output logic                  nullSeen,
    output logic                  escError,
    output logic                  parError,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    localparam logic [1:0] L_FCT = 2'd0;
    localparam logic [1:0] L_EEP = 2'd1;
    localparam logic [1:0] L_EOP = 2'd2;
    localparam logic [1:0] L_ESC = 2'd3;

    typedef enum logic [2:0] {
        WAIT_NULL,
        WAIT_ESC,
        RUN,
        ESC,
        HALT
    } state_t;

    state_t state, state_next;

    logic       is_fct, is_eep, is_eop, is_esc;
    logic       push_req;
    logic [8:0] push_data;
    logic       null_hit, fct_hit, tick_hit, esc_bad;

    logic [8:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic                  pop, full, push_ok;

    always_comb begin
        state_next = state;
        push_req   = 1'b0;
        push_data  = 9'h000;
        null_hit   = 1'b0;
        fct_hit    = 1'b0;
        tick_hit   = 1'b0;
        esc_bad    = 1'b0;
        is_fct     = lchar && (q[1:0] == L_FCT);
        is_eep     = lchar && (q[1:0] == L_EEP);
        is_eop     = lchar && (q[1:0] == L_EOP);
        is_esc     = lchar && (q[1:0] == L_ESC);

        // A parity failure wins over any char strobed in the same cycle.
        if (parityError) begin
            state_next = HALT;
        end else begin
            unique case (state)
                WAIT_NULL: begin
                    if (is_esc) state_next = WAIT_ESC;
                end
                WAIT_ESC: begin
                    if (is_fct) begin
                        null_hit   = 1'b1;
                        state_next = RUN;
                    end else if (nchar || (lchar && !is_esc)) begin
                        state_next = WAIT_NULL;
                    end
                end
                RUN: begin
                    if (nchar) begin
                        push_req  = 1'b1;
                        push_data = {1'b0, q};
                    end else if (is_eop) begin
                        push_req  = 1'b1;
                        push_data = 9'h100;
                    end else if (is_eep) begin
                        push_req  = 1'b1;
                        push_data = 9'h101;
                    end else if (is_fct) begin
                        fct_hit = 1'b1;
                    end else if (is_esc) begin
                        state_next = ESC;
                    end
                end
                ESC: begin
                    if (is_fct) begin
                        null_hit   = 1'b1;
                        state_next = RUN;
                    end else if (nchar) begin
                        tick_hit   = 1'b1;
                        state_next = RUN;
                    end else if (lchar) begin
                        esc_bad    = 1'b1;
                        state_next = HALT;
                    end
                end
                HALT: begin
                    state_next = HALT;
                end
                default: begin
                    state_next = HALT;
                end
            endcase
        end
    end

    assign rdValid = (fifoCount != '0);
    assign full    = (fifoCount == FULL_CNT);
    assign pop     = rdValid && rdReady;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push_req && (!full || pop);
    assign rdData  = rdValid ? mem[rd_ptr] : 9'h000;

    always_ff @(posedge rxClk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge rxClk or posedge rxReset) begin
        if (rxReset) begin
            state     <= WAIT_NULL;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifoCount <= '0;
            gotNull   <= 1'b0;
            gotFct    <= 1'b0;
            tick      <= 1'b0;
            timeCode  <= 8'h00;
            nullSeen  <= 1'b0;
            escError  <= 1'b0;
            parError  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state   <= state_next;
            gotNull <= null_hit;
            gotFct  <= fct_hit;
            tick    <= tick_hit;
            if (tick_hit)    timeCode <= q;
            if (null_hit)    nullSeen <= 1'b1;
            if (esc_bad)     escError <= 1'b1;
            if (parityError) parError <= 1'b1;
            if (push_req && !push_ok) overflow <= 1'b1;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      fifoCount <= fifoCount + 1'b1;
            else if (pop && !push_ok) fifoCount <= fifoCount - 1'b1;
        end
    end

endmodule

// File: tb/tb_rx_ds_token.sv
// tb_rx_ds_token: directed and randomized checks of rx_ds_token
// against a token-level reference model.
module tb_rx_ds_token;

    logic       rxClk = 1'b0;
    logic       rxReset;
    logic [7:0] q;
    logic       nchar, lchar, parityError, rdReady;
    logic [8:0] rdData;
    logic       rdValid;
    logic [3:0] fifoCount;
    logic       gotNull, gotFct, tick;
    logic [7:0] timeCode;
    logic       nullSeen, escError, parError, overflow;

    int n_cmp = 0;
    int n_err = 0;

    rx_ds_token dut (
        .rxClk(rxClk), .rxReset(rxReset), .q(q), .nchar(nchar),
        .lchar(lchar), .parityError(parityError), .rdData(rdData),
        .rdValid(rdValid), .rdReady(rdReady), .fifoCount(fifoCount),
        .gotNull(gotNull), .gotFct(gotFct), .tick(tick),
        .timeCode(timeCode), .nullSeen(nullSeen), .escError(escError),
        .parError(parError), .overflow(overflow)
    );

    always #5 rxClk = ~rxClk;

    // Reference model: token-level view of the link.
    logic [8:0] mq[$];
    bit   m_linked, m_esc, m_halt;
    bit   m_null, m_fct, m_tick;
    bit   m_seen, m_escerr, m_par, m_ovf;
    logic [7:0] m_tc;

    task automatic model_clear();
        mq.delete();
        m_linked = 0; m_esc = 0; m_halt = 0;
        m_null = 0; m_fct = 0; m_tick = 0;
        m_seen = 0; m_escerr = 0; m_par = 0; m_ovf = 0;
        m_tc = 8'h00;
    endtask

    task automatic model_push(input logic [8:0] d);
        if (mq.size() >= 8) m_ovf = 1;
        else mq.push_back(d);
    endtask

    task automatic model_step(input bit nc, input bit lc,
                              input logic [1:0] code, input logic [7:0] d,
                              input bit perr, input bit rdy);
        bit e_esc, e_fct;
        if (rdy && mq.size() != 0) void'(mq.pop_front());
        m_null = 0; m_fct = 0; m_tick = 0;
        e_esc = lc && code == 2'd3;
        e_fct = lc && code == 2'd0;
        if (perr) begin
            m_par = 1;
            m_halt = 1;
        end else if (!m_halt && (nc || lc)) begin
            if (m_esc) begin
                m_esc = 0;
                if (e_fct) begin
                    m_null = 1; m_seen = 1; m_linked = 1;
                end else if (m_linked) begin
                    if (nc) begin
                        m_tick = 1; m_tc = d;
                    end else begin
                        m_escerr = 1; m_halt = 1;
                    end
                end else if (e_esc) begin
                    m_esc = 1;
                end
            end else if (e_esc) begin
                m_esc = 1;
            end else if (m_linked) begin
                if (nc) model_push({1'b0, d});
                else if (code == 2'd2) model_push(9'h100);
                else if (code == 2'd1) model_push(9'h101);
                else m_fct = 1;
            end
        end
    endtask

    function automatic logic [28:0] model_vec();
        logic [8:0] head;
        logic [3:0] cnt;
        head = (mq.size() != 0) ? mq[0] : 9'h000;
        cnt  = 4'(mq.size());
        return {mq.size() != 0, head, cnt, m_null, m_fct, m_tick,
                m_tc, m_seen, m_escerr, m_par, m_ovf};
    endfunction

    wire [28:0] dut_vec = {rdValid, rdData, fifoCount, gotNull, gotFct,
                           tick, timeCode, nullSeen, escError, parError,
                           overflow};

    task automatic cyc(input bit nc, input bit lc, input logic [1:0] code,
                       input logic [7:0] d, input bit perr, input bit rdy);
        @(negedge rxClk);
        nchar = nc; lchar = lc; parityError = perr; rdReady = rdy;
        q = lc ? {6'h00, code} : d;
        model_step(nc, lc, code, d, perr, rdy);
        @(posedge rxClk);
        #1;
    endtask

    task automatic send_n(input logic [7:0] d, input bit rdy);
        cyc(1, 0, 2'd0, d, 0, rdy);
    endtask

    task automatic send_l(input logic [1:0] code, input bit rdy);
        cyc(0, 1, code, 8'h00, 0, rdy);
    endtask

    task automatic idle(input bit rdy);
        cyc(0, 0, 2'd0, 8'h00, 0, rdy);
    endtask

    task automatic send_null();
        send_l(2'd3, 0);
        send_l(2'd0, 0);
    endtask

    task automatic do_reset();
        @(negedge rxClk);
        rxReset = 1; nchar = 0; lchar = 0; parityError = 0;
        rdReady = 0; q = 8'h00;
        @(negedge rxClk);
        rxReset = 0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (dut_vec !== 29'h0) begin
            n_err++;
            $display("FAIL reset_state: got %h want 0", dut_vec);
        end
        send_n(8'h41, 0);
        idle(0);
        n_cmp++;
        if ({rdValid, nullSeen, fifoCount} !== 6'h0) begin
            n_err++;
            $display("FAIL prelink_nchar: valid=%b seen=%b cnt=%0d want 0",
                     rdValid, nullSeen, fifoCount);
        end
    endtask

    task automatic test_null_eop();
        send_null();
        n_cmp++;
        if (gotNull !== 1'b1 || nullSeen !== 1'b1) begin
            n_err++;
            $display("FAIL first_null: gotNull=%b seen=%b want 1 1",
                     gotNull, nullSeen);
        end
        send_l(2'd3, 0);
        n_cmp++;
        if (gotNull !== 1'b0) begin
            n_err++;
            $display("FAIL null_pulse_width: gotNull=%b want 0", gotNull);
        end
        send_l(2'd0, 0);
        n_cmp++;
        if (gotNull !== 1'b1) begin
            n_err++;
            $display("FAIL second_null: gotNull=%b want 1", gotNull);
        end
        send_n(8'h41, 0);
        send_l(2'd2, 0);
        n_cmp++;
        if (fifoCount !== 4'd2 || rdData !== 9'h041) begin
            n_err++;
            $display("FAIL data_eop_head: cnt=%0d head=%h want 2 041",
                     fifoCount, rdData);
        end
        idle(1);
        n_cmp++;
        if (rdData !== 9'h100 || rdValid !== 1'b1) begin
            n_err++;
            $display("FAIL eop_marker: head=%h valid=%b want 100 1",
                     rdData, rdValid);
        end
        idle(1);
        n_cmp++;
        if (dut_vec !== model_vec()) begin
            n_err++;
            $display("FAIL null_eop_model: got %h want %h",
                     dut_vec, model_vec());
        end
    endtask

    task automatic test_timecode();
        send_l(2'd3, 0);
        send_n(8'h4F, 0);
        n_cmp++;
        if (tick !== 1'b1 || timeCode !== 8'h4F || fifoCount !== 4'd0) begin
            n_err++;
            $display("FAIL timecode: tick=%b tc=%h cnt=%0d want 1 4f 0",
                     tick, timeCode, fifoCount);
        end
        send_l(2'd0, 0);
        n_cmp++;
        if (tick !== 1'b0 || gotFct !== 1'b1) begin
            n_err++;
            $display("FAIL bare_fct: tick=%b fct=%b want 0 1", tick, gotFct);
        end
    endtask

    task automatic test_esc_error();
        send_l(2'd3, 0);
        send_l(2'd2, 0);
        n_cmp++;
        if (escError !== 1'b1) begin
            n_err++;
            $display("FAIL esc_eop: escError=%b want 1", escError);
        end
        send_n(8'h62, 0);
        idle(0);
        n_cmp++;
        if (rdValid !== 1'b0 || fifoCount !== 4'd0) begin
            n_err++;
            $display("FAIL halt_ignore: valid=%b cnt=%0d want 0 0",
                     rdValid, fifoCount);
        end
        do_reset();
        n_cmp++;
        if (escError !== 1'b0) begin
            n_err++;
            $display("FAIL esc_reset: escError=%b want 0", escError);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        send_null();
        for (int i = 1; i <= 9; i++) send_n(8'(i), 0);
        n_cmp++;
        if (fifoCount !== 4'd8 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL overflow: cnt=%0d ovf=%b want 8 1",
                     fifoCount, overflow);
        end
        for (int i = 1; i <= 8; i++) begin
            n_cmp++;
            if (rdData !== {1'b0, 8'(i)}) begin
                n_err++;
                $display("FAIL drain_%0d: head=%h want %h",
                         i, rdData, {1'b0, 8'(i)});
            end
            idle(1);
        end
        n_cmp++;
        if (rdValid !== 1'b0) begin
            n_err++;
            $display("FAIL drain_empty: valid=%b want 0", rdValid);
        end
    endtask

    task automatic test_parity();
        do_reset();
        send_null();
        send_n(8'hA1, 0);
        send_n(8'hA2, 0);
        cyc(1, 0, 2'd0, 8'hA3, 1, 0);
        n_cmp++;
        if (parError !== 1'b1 || fifoCount !== 4'd2) begin
            n_err++;
            $display("FAIL parity: par=%b cnt=%0d want 1 2",
                     parError, fifoCount);
        end
        send_n(8'hA4, 0);
        n_cmp++;
        if (fifoCount !== 4'd2 || rdData !== 9'h0A1) begin
            n_err++;
            $display("FAIL parity_halt: cnt=%0d head=%h want 2 0a1",
                     fifoCount, rdData);
        end
        idle(1);
        n_cmp++;
        if (rdData !== 9'h0A2) begin
            n_err++;
            $display("FAIL parity_drain: head=%h want 0a2", rdData);
        end
        idle(1);
        n_cmp++;
        if (dut_vec !== model_vec()) begin
            n_err++;
            $display("FAIL parity_model: got %h want %h",
                     dut_vec, model_vec());
        end
    endtask

    task automatic test_random();
        int k;
        bit rdy;
        for (int seg = 0; seg < 4; seg++) begin
            do_reset();
            send_null();
            for (int c = 0; c < 150; c++) begin
                rdy = ($urandom_range(0, 9) < ((seg < 2) ? 3 : 7));
                k = $urandom_range(0, 19);
                if (k == 0 && $urandom_range(0, 9) == 0)
                    cyc(1, 0, 2'd0, 8'($urandom), 1, rdy);
                else if (k < 9)
                    send_n(8'($urandom), rdy);
                else if (k < 11)
                    send_l(2'd0, rdy);
                else if (k < 13)
                    send_l(2'd2, rdy);
                else if (k < 14)
                    send_l(2'd1, rdy);
                else if (k < 16)
                    send_l(2'd3, rdy);
                else
                    idle(rdy);
                n_cmp++;
                if (dut_vec !== model_vec()) begin
                    n_err++;
                    $display("FAIL random_s%0d_c%0d: got %h want %h",
                             seg, c, dut_vec, model_vec());
                end
            end
        end
    endtask

    initial begin
        rxReset = 1; q = 8'h00; nchar = 0; lchar = 0;
        parityError = 0; rdReady = 0;
        model_clear();
        test_reset();
        test_null_eop();
        test_timecode();
        test_esc_error();
        test_overflow();
        test_parity();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
